// File: rtl/sme_char_feeder_if.sv
// Byte-stream record interface into the string-matching feeder.
// The source (master) frames string and pattern records; the feeder (slave) applies backpressure.
interface sme_char_feeder_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_is_pat;
    logic       in_last;

    modport master (output in_valid, in_data, in_is_pat, in_last, input in_ready);
    modport slave  (input in_valid, in_data, in_is_pat, in_last, output in_ready);
endinterface

// File: rtl/sme_char_feeder.sv
// sme_char_feeder: buffers framed string/pattern records in two ping-pong buffers
// and replays them to the matching engine as gapless string->pattern bursts.
// Build option: define OVERLEN_ERR_EN to discard over-length records and pulse ovl_err;
// otherwise over-length records are truncated and ovl_err stays 0.
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | nothing released; outputs 0
// PRESENT | byte0 of released record driven, waits for engine acceptance
// STREAM  | one byte per cycle, string rolls straight into its pattern
// GAP     | single zero cycle after a pattern's last byte
module sme_char_feeder #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    sme_char_feeder_if.slave        in_if,
    output logic [7:0]              chardata,
    output logic                    isstring,
    output logic                    ispattern,
    input  logic                    sme_valid,
    output logic                    expect_res,
    output logic                    seq_err,
    output logic                    ovl_err
);
    localparam int LW = $clog2(STR_MAX + 1);
    localparam int IW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
    localparam logic [LW-1:0] STR_LIM = LW'(STR_MAX);
    localparam logic [LW-1:0] PAT_LIM = LW'(PAT_MAX);
`ifdef OVERLEN_ERR_EN
    localparam bit OVL_EN = 1'b1;
`else
    localparam bit OVL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_STREAM, S_GAP} state_t;

    state_t        state_q, state_d;
    logic          started_q, started_d;
    logic          str_seen_q, str_seen_d;
    // occ: buffer holds a complete record not yet fully emitted; rel: it has been released
    logic [1:0]    occ_q, occ_d;
    logic [1:0]    rel_q, rel_d;
    logic [1:0]    bpat_q, bpat_d;
    logic [LW-1:0] len_q [2];
    logic [LW-1:0] len_d [2];
    logic [7:0]    mem_q [2][STR_MAX];
    logic [7:0]    mem_d [2][STR_MAX];
    logic          fill_q, fill_d;
    logic          fill_sel_q, fill_sel_d;
    logic          fill_pat_q, fill_pat_d;
    logic [LW-1:0] fill_cnt_q, fill_cnt_d;
    logic          fill_ovf_q, fill_ovf_d;
    logic          rd_sel_q, rd_sel_d;
    logic [LW-1:0] rd_idx_q, rd_idx_d;
    logic          expect_res_q, expect_res_d;
    logic          seq_err_q, seq_err_d;
    logic          ovl_err_q, ovl_err_d;

    logic          xfer, cur_sel, cur_pat, room, ovf_now;
    logic [LW-1:0] cur_cnt, lim, new_cnt;
    logic [1:0]    str_wait, pat_rdy;
    logic          rel_any, rel_sel;

    // Backpressure only when both buffers are committed to complete records
    assign in_if.in_ready = ~(occ_q[0] & occ_q[1]);
    assign xfer           = in_if.in_valid & in_if.in_ready;
    assign expect_res     = expect_res_q;
    assign seq_err        = seq_err_q;
    assign ovl_err        = ovl_err_q;

    // Decode the incoming byte: target buffer, record type, stored length, overflow
    always_comb begin
        cur_sel = fill_q ? fill_sel_q : occ_q[0];
        cur_pat = fill_q ? fill_pat_q : in_if.in_is_pat;
        cur_cnt = fill_q ? fill_cnt_q : '0;
        lim     = cur_pat ? PAT_LIM : STR_LIM;
        room    = cur_cnt < lim;
        new_cnt = room ? cur_cnt + LW'(1) : cur_cnt;
        ovf_now = (fill_q & fill_ovf_q) | ~room;
    end

    // Find a releasable record; a string is only releasable with its pattern beside it
    always_comb begin
        str_wait = occ_q & ~rel_q & ~bpat_q;
        pat_rdy  = occ_q & ~rel_q & bpat_q;
        rel_any  = 1'b1;
        rel_sel  = 1'b0;
        if (str_wait[0] && pat_rdy[1]) begin
            rel_sel = 1'b0;
        end else if (str_wait[1] && pat_rdy[0]) begin
            rel_sel = 1'b1;
        end else if (pat_rdy[0]) begin
            rel_sel = 1'b0;
        end else if (pat_rdy[1]) begin
            rel_sel = 1'b1;
        end else begin
            rel_any = 1'b0;
        end
    end

    // Buffer fill, sequencing checks and replay FSM next-state
    always_comb begin
        state_d      = state_q;
        started_d    = started_q;
        str_seen_d   = str_seen_q;
        occ_d        = occ_q;
        rel_d        = rel_q;
        bpat_d       = bpat_q;
        len_d        = len_q;
        mem_d        = mem_q;
        fill_d       = fill_q;
        fill_sel_d   = fill_sel_q;
        fill_pat_d   = fill_pat_q;
        fill_cnt_d   = fill_cnt_q;
        fill_ovf_d   = fill_ovf_q;
        rd_sel_d     = rd_sel_q;
        rd_idx_d     = rd_idx_q;
        seq_err_d    = 1'b0;
        ovl_err_d    = 1'b0;
        expect_res_d = sme_valid ? 1'b0 : expect_res_q;

        if (xfer) begin
            if (room) begin
                mem_d[cur_sel][cur_cnt[IW-1:0]] = in_if.in_data;
            end
            if (in_if.in_last) begin
                fill_d = 1'b0;
                if (OVL_EN && ovf_now) begin
                    ovl_err_d = 1'b1;
                end else if (cur_pat && !str_seen_q) begin
                    seq_err_d = 1'b1;
                end else begin
                    occ_d[cur_sel]  = 1'b1;
                    rel_d[cur_sel]  = 1'b0;
                    bpat_d[cur_sel] = cur_pat;
                    len_d[cur_sel]  = new_cnt;
                    if (!cur_pat) begin
                        str_seen_d = 1'b1;
                        // An older string still waiting for its pattern is superseded
                        if (str_wait[~cur_sel]) begin
                            occ_d[~cur_sel] = 1'b0;
                            seq_err_d       = 1'b1;
                        end
                    end
                end
            end else begin
                fill_d     = 1'b1;
                fill_sel_d = cur_sel;
                fill_pat_d = cur_pat;
                fill_cnt_d = new_cnt;
                fill_ovf_d = ovf_now;
            end
        end

        case (state_q)
            S_IDLE, S_GAP: begin
                if (state_q == S_GAP) begin
                    started_d = 1'b1;
                end
                if (rel_any) begin
                    state_d         = S_PRESENT;
                    rd_sel_d        = rel_sel;
                    rd_idx_d        = '0;
                    rel_d[rel_sel]  = 1'b1;
                    if (!bpat_q[rel_sel]) begin
                        rel_d[~rel_sel] = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRESENT, S_STREAM: begin
                if (state_q == S_STREAM || !started_q || sme_valid) begin
                    if (rd_idx_q == len_q[rd_sel_q] - LW'(1)) begin
                        occ_d[rd_sel_q] = 1'b0;
                        rel_d[rd_sel_q] = 1'b0;
                        if (!bpat_q[rd_sel_q]) begin
                            rd_sel_d = ~rd_sel_q;
                            rd_idx_d = '0;
                            state_d  = S_STREAM;
                        end else begin
                            expect_res_d = 1'b1;
                            state_d      = S_GAP;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + LW'(1);
                        state_d  = S_STREAM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Engine-facing outputs, zero outside PRESENT/STREAM
    always_comb begin
        chardata  = 8'h00;
        isstring  = 1'b0;
        ispattern = 1'b0;
        if (state_q == S_PRESENT || state_q == S_STREAM) begin
            chardata  = mem_q[rd_sel_q][rd_idx_q[IW-1:0]];
            isstring  = ~bpat_q[rd_sel_q];
            ispattern = bpat_q[rd_sel_q];
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            started_q    <= 1'b0;
            str_seen_q   <= 1'b0;
            occ_q        <= '0;
            rel_q        <= '0;
            bpat_q       <= '0;
            fill_q       <= 1'b0;
            fill_sel_q   <= 1'b0;
            fill_pat_q   <= 1'b0;
            fill_cnt_q   <= '0;
            fill_ovf_q   <= 1'b0;
            rd_sel_q     <= 1'b0;
            rd_idx_q     <= '0;
            expect_res_q <= 1'b0;
            seq_err_q    <= 1'b0;
            ovl_err_q    <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                len_q[b] <= '0;
                for (int i = 0; i < STR_MAX; i++) begin
                    mem_q[b][i] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            started_q    <= started_d;
            str_seen_q   <= str_seen_d;
            occ_q        <= occ_d;
            rel_q        <= rel_d;
            bpat_q       <= bpat_d;
            fill_q       <= fill_d;
            fill_sel_q   <= fill_sel_d;
            fill_pat_q   <= fill_pat_d;
            fill_cnt_q   <= fill_cnt_d;
            fill_ovf_q   <= fill_ovf_d;
            rd_sel_q     <= rd_sel_d;
            rd_idx_q     <= rd_idx_d;
            expect_res_q <= expect_res_d;
            seq_err_q    <= seq_err_d;
            ovl_err_q    <= ovl_err_d;
            len_q        <= len_d;
            mem_q        <= mem_d;
        end
    end
endmodule

// File: tb/tb_sme_char_feeder.sv
// Directed bench for sme_char_feeder: stimulus is driven 1 time unit after each rising edge
// and outputs are sampled at that same point; the engine-side invariants are checked on falling edges.
module tb_sme_char_feeder;
    logic       clk = 1'b0;
    logic       reset;
    logic       sme_valid;
    logic [7:0] chardata;
    logic       isstring, ispattern, expect_res, seq_err, ovl_err;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_fail = 0;

`ifdef OVERLEN_ERR_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    sme_char_feeder_if bus ();

    sme_char_feeder #(.STR_MAX(32), .PAT_MAX(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_if      (bus),
        .chardata   (chardata),
        .isstring   (isstring),
        .ispattern  (ispattern),
        .sme_valid  (sme_valid),
        .expect_res (expect_res),
        .seq_err    (seq_err),
        .ovl_err    (ovl_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic s, input logic p, input logic [7:0] d);
        chk(tag, {22'b0, isstring, ispattern, chardata}, {22'b0, s, p, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic p, input logic l);
        int w = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_is_pat = p;
        bus.in_last   = l;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("in_ready", {31'b0, bus.in_ready}, 1);
        tick();
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_is_pat = 1'b0;
        bus.in_last   = 1'b0;
    endtask

    task automatic send_rec(input string s, input logic p);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], p, i == s.len() - 1);
        end
    endtask

    task automatic wait_active();
        int w = 0;
        while (!(isstring || ispattern) && w < 30) begin
            tick();
            w++;
        end
        chk("burst_start", {31'b0, isstring | ispattern}, 1);
    endtask

    task automatic pulse_sme();
        sme_valid = 1'b1;
        tick();
        sme_valid = 1'b0;
    endtask

    // Engine-side invariants on every cycle out of reset
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("flags_exclusive", {31'b0, isstring & ispattern}, 0);
            if (!isstring && !ispattern) chk("idle_chardata", {24'b0, chardata}, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        sme_valid     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_is_pat = 1'b0;
        bus.in_last   = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", {31'b0, bus.in_ready}, 1);
        chk_out("rst_out", 1'b0, 1'b0, 8'h00);
        chk("rst_flags", {29'b0, expect_res, seq_err, ovl_err}, 0);
        reset = 1'b0;

        // 1: string "ab" is held until pattern "b" arrives, then gapless burst
        send_rec("ab", 1'b0);
        repeat (3) tick();
        chk_out("t1_str_held", 1'b0, 1'b0, 8'h00);
        send_rec("b", 1'b1);
        wait_active();
        chk_out("t1_s0", 1'b1, 1'b0, 8'h61);
        tick();
        chk_out("t1_s1", 1'b1, 1'b0, 8'h62);
        chk("t1_exp_pre", {31'b0, expect_res}, 0);
        tick();
        chk_out("t1_p0", 1'b0, 1'b1, 8'h62);
        tick();
        chk_out("t1_gap", 1'b0, 1'b0, 8'h00);
        chk("t1_exp_set", {31'b0, expect_res}, 1);
        tick();
        chk_out("t1_idle", 1'b0, 1'b0, 8'h00);
        chk("t1_exp_hold", {31'b0, expect_res}, 1);

        // 2: lone pattern "a" waits for the engine pulse
        send_rec("a", 1'b1);
        wait_active();
        chk_out("t2_present", 1'b0, 1'b1, 8'h61);
        repeat (3) tick();
        chk_out("t2_held", 1'b0, 1'b1, 8'h61);
        pulse_sme();
        chk_out("t2_after", 1'b0, 1'b0, 8'h00);
        chk("t2_exp", {31'b0, expect_res}, 1);

        // 5: two pulses with nothing buffered, then a pattern waits for the next pulse
        tick();
        pulse_sme();
        chk("t5_clear", {31'b0, expect_res}, 0);
        pulse_sme();
        chk("t5_spurious", {31'b0, expect_res}, 0);
        chk_out("t5_idle", 1'b0, 1'b0, 8'h00);
        send_rec("c", 1'b1);
        wait_active();
        chk_out("t5_present", 1'b0, 1'b1, 8'h63);
        repeat (2) tick();
        chk_out("t5_held", 1'b0, 1'b1, 8'h63);
        pulse_sme();
        chk_out("t5_after", 1'b0, 1'b0, 8'h00);
        chk("t5_exp", {31'b0, expect_res}, 1);

        // 4: 9-byte pattern
        send_rec("123456789", 1'b1);
        chk("t4_ovl_pulse", {31'b0, ovl_err}, {31'b0, OVL});
        tick();
        chk("t4_ovl_clear", {31'b0, ovl_err}, 0);
        if (OVL) begin
            repeat (6) begin
                tick();
                chk_out("t4_dropped", 1'b0, 1'b0, 8'h00);
            end
        end else begin
            wait_active();
            chk_out("t4_b0", 1'b0, 1'b1, 8'h31);
            pulse_sme();
            chk_out("t4_b1", 1'b0, 1'b1, 8'h32);
            chk("t4_exp_clr", {31'b0, expect_res}, 0);
            for (int k = 2; k < 8; k++) begin
                tick();
                chk_out("t4_bk", 1'b0, 1'b1, 8'(8'h31 + k));
            end
            tick();
            chk_out("t4_gap", 1'b0, 1'b0, 8'h00);
            chk("t4_exp", {31'b0, expect_res}, 1);
        end

        // 3: reset, then a pattern before any string is dropped
        chk("t3_exp_pre", {31'b0, expect_res}, 1);
        reset = 1'b1;
        #1;
        chk("t3_exp_rst", {31'b0, expect_res}, 0);
        tick();
        reset = 1'b0;
        send_rec("x", 1'b1);
        chk("t3_seq_pulse", {31'b0, seq_err}, 1);
        tick();
        chk("t3_seq_clear", {31'b0, seq_err}, 0);
        repeat (4) tick();
        chk_out("t3_no_pat", 1'b0, 1'b0, 8'h00);
        chk("t3_in_ready", {31'b0, bus.in_ready}, 1);

        // 6: reset in the middle of a string burst
        send_rec("wxyz", 1'b0);
        send_rec("y", 1'b1);
        wait_active();
        chk_out("t6_s0", 1'b1, 1'b0, 8'h77);
        tick();
        chk_out("t6_s1", 1'b1, 1'b0, 8'h78);
        reset = 1'b1;
        #1;
        chk_out("t6_rst_out", 1'b0, 1'b0, 8'h00);
        chk("t6_rst_misc", {30'b0, bus.in_ready, expect_res}, 32'h2);
        tick();
        reset = 1'b0;
        send_rec("pq", 1'b0);
        repeat (3) tick();
        chk_out("t6_str_held", 1'b0, 1'b0, 8'h00);
        send_rec("rs", 1'b0);
        chk("t6_replace", {31'b0, seq_err}, 1);
        send_rec("s", 1'b1);
        wait_active();
        chk_out("t6_r0", 1'b1, 1'b0, 8'h72);
        tick();
        chk_out("t6_r1", 1'b1, 1'b0, 8'h73);
        tick();
        chk_out("t6_p0", 1'b0, 1'b1, 8'h73);
        tick();
        chk_out("t6_gap", 1'b0, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
